// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and data-memory port bundle for load_store_unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] load_data;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  // master: pipeline plus memory environment; slave: the load/store unit
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, Read_Data,
    input  busy, resp_valid, resp_err, load_data, Mem_Addr, Write_Data, MemWrite, MemRead
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, Read_Data,
    output busy, resp_valid, resp_err, load_data, Mem_Addr, Write_Data, MemWrite, MemRead
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with lane extraction and byte-merge RMW
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [63:0] RANGE_MAX = 64'(MEM_BYTES - 8);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic        busy_q, resp_valid_q, resp_err_q, mem_rd_q, mem_wr_q;
  logic [63:0] load_data_q, mem_addr_q, write_data_q;

  logic [63:0] req_aligned;
  logic        misaligned, out_of_range, illegal, req_err;
  logic [5:0]  lane_shift;
  logic [63:0] rd_shifted, extracted, size_mask, lane_mask, merged;

  always_comb begin
    req_aligned = {bus.req_addr[63:3], 3'b000};
    misaligned  = 1'b0;
    case (bus.req_funct3[1:0])
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      2'd3:    misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    // compare the aligned base against the last legal base to avoid +7 overflow
    out_of_range = req_aligned > RANGE_MAX;
    illegal      = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    req_err      = misaligned | out_of_range | illegal;
  end

  always_comb begin
    lane_shift = {off_q, 3'b000};
    rd_shifted = bus.Read_Data >> lane_shift;
    case (funct3_q)
      3'b000:  extracted = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
      3'b001:  extracted = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  extracted = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      3'b100:  extracted = {56'd0, rd_shifted[7:0]};
      3'b101:  extracted = {48'd0, rd_shifted[15:0]};
      3'b110:  extracted = {32'd0, rd_shifted[31:0]};
      default: extracted = rd_shifted;
    endcase
    case (funct3_q[1:0])
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    lane_mask = size_mask << lane_shift;
    merged    = (bus.Read_Data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      funct3_q     <= 3'd0;
      off_q        <= 3'd0;
      wdata_q      <= 64'd0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      load_data_q  <= 64'd0;
      mem_addr_q   <= 64'd0;
      write_data_q <= 64'd0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q   <= bus.req_funct3;
            off_q      <= bus.req_addr[2:0];
            wdata_q    <= bus.req_wdata;
            mem_addr_q <= req_aligned;
            busy_q     <= 1'b1;
            resp_err_q <= req_err;
            if (req_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end else if (!bus.req_write) begin
              state    <= LOAD;
              mem_rd_q <= 1'b1;
            end else if (bus.req_funct3[1:0] == 2'd3) begin
              state        <= STORE;
              mem_wr_q     <= 1'b1;
              write_data_q <= bus.req_wdata;
            end else begin
              state    <= RMW_RD;
              mem_rd_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          load_data_q  <= extracted;
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
        STORE: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
        RMW_RD: begin
          write_data_q <= merged;
          mem_wr_q     <= 1'b1;
          state        <= RMW_WR;
        end
        RMW_WR: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // strobes are masked by reset so an aborted RMW can never land its write
  assign bus.MemRead    = mem_rd_q & ~reset;
  assign bus.MemWrite   = mem_wr_q & ~reset;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.load_data  = load_data_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Write_Data = write_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a byte-array reference memory
module tb_load_store_unit;
  localparam int MEM_BYTES = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [63:0] dmem [8];
  assign bus.Read_Data = dmem[bus.Mem_Addr[5:3]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 8; i++) dmem[i] <= 64'd0;
    end else if (bus.MemWrite) begin
      dmem[bus.Mem_Addr[5:3]] <= bus.Write_Data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [63:0] data;
    logic [63:0] addr;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [63:0] ref_ld = 64'd0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
      chk("memwrite_in_reset", 64'(bus.MemWrite), 64'd0);
    end else begin
      if (bus.MemRead) rd_cnt++;
      if (bus.MemWrite) wr_cnt++;
      if ((bus.MemRead || bus.MemWrite) && sb.size() > 0)
        chk("mem_addr", bus.Mem_Addr, sb[0].addr);
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          cur = sb.pop_front();
          chk("resp_err", 64'(bus.resp_err), 64'(cur.err));
          chk("load_data", bus.load_data, cur.data);
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
          chk("memread_cycles", 64'(rd_cnt), 64'(cur.rd));
          chk("memwrite_cycles", 64'(wr_cnt), 64'(cur.wr));
          chk("busy_in_resp", 64'(bus.busy), 64'd1);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Reference: plain byte-addressed memory and the architectural load/store rules.
  function automatic exp_t model(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] wd);
    exp_t        e;
    int          n;
    logic [63:0] v;
    logic [63:0] one;
    n     = 1 << f3[1:0];
    one   = 64'd1;
    e.addr = addr & ~64'h7;
    e.err = ((addr % 64'(n)) != 0) || (e.addr + 7 >= 64'(MEM_BYTES)) ||
            (w ? (f3 >= 3'd4) : (f3 == 3'd7));
    e.rd  = 0;
    e.wr  = 0;
    e.lat = 1;
    if (!e.err) begin
      if (!w) begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[addr + 64'(i)]) << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((one << (8 * n)) - 1);
        ref_ld = v;
        e.rd   = 1;
        e.lat  = 2;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wd[8*i +: 8];
        e.wr  = 1;
        e.rd  = (n < 8) ? 1 : 0;
        e.lat = (n < 8) ? 3 : 2;
      end
    end
    e.data = ref_ld;
    return e;
  endfunction

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input bit track);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (bus.busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got busy=1 expected busy=0 within 20 cycles");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (track) begin
      e     = model(w, f3, addr, wd);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  initial begin
    int          waited;
    logic        w;
    logic [2:0]  f3;
    logic [63:0] dw;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_clear = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_load_data", bus.load_data, 64'd0);
    chk("rst_mem_addr", bus.Mem_Addr, 64'd0);
    chk("rst_write_data", bus.Write_Data, 64'd0);

    issue(1'b1, 3'd3, 64'd8, 64'h1122334455667788, 1'b1);
    issue(1'b0, 3'd0, 64'd15, 64'd0, 1'b1);
    issue(1'b0, 3'd0, 64'd8, 64'd0, 1'b1);
    issue(1'b0, 3'd4, 64'd8, 64'd0, 1'b1);
    issue(1'b1, 3'd1, 64'd10, 64'h000000000000ABCD, 1'b1);
    issue(1'b0, 3'd3, 64'd8, 64'd0, 1'b1);
    issue(1'b0, 3'd2, 64'd6, 64'd0, 1'b1);
    issue(1'b0, 3'd1, 64'd9, 64'd0, 1'b1);
    issue(1'b0, 3'd3, 64'd64, 64'd0, 1'b1);
    issue(1'b0, 3'd7, 64'd16, 64'd0, 1'b1);

    // a request presented while busy must be dropped
    issue(1'b0, 3'd3, 64'd8, 64'd0, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'hFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;

    // reset while the RMW read is in flight
    issue(1'b1, 3'd0, 64'd3, 64'hFF, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_memwrite", 64'(bus.MemWrite), 64'd0);
    chk("abort_memread", 64'(bus.MemRead), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    ref_ld = 64'd0;
    @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_rst_load_data", bus.load_data, 64'd0);
    issue(1'b0, 3'd3, 64'd0, 64'd0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      else f3 = 3'($urandom_range(0, 7));
      issue(w, f3, 64'($urandom_range(0, 75)), {$urandom, $urandom}, 1'b1);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      dw = 64'd0;
      for (int b = 0; b < 8; b++) dw[8*b +: 8] = ref_mem[8*d + b];
      chk($sformatf("final_mem[%0d]", d), dmem[d], dw);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator that turns pipeline load/store requests into accesses on the doubleword data-memory port (Mem_Addr / Write_Data / MemWrite / MemRead / Read_Data).
- Loads: byte lane extraction plus sign/zero extension.
- SB/SH/SW: read-modify-write, because the memory port only writes whole doublewords.
- Alignment and range checks are done here, and `busy` stalls the pipeline until the access completes.

Parameters:
MEM_BYTES, 64, byte capacity of the attached data memory; any access with aligned address + 7 >= MEM_BYTES is out of range.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  pipeline request strobe; sampled only when busy=0
req_write  input  1  1=store, 0=load
req_funct3  input  3  RV64 funct3 (load 000..110, store 000..011)
req_addr  input  64  byte address
req_wdata  input  64  store data; low bytes used for SB/SH/SW
busy  output  1  stall; 0 only in IDLE
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3
load_data  output  64  extended load result; valid with resp_valid, held until next response
Mem_Addr  output  64  doubleword-aligned address to memory
Write_Data  output  64  doubleword to memory
MemWrite  output  1  memory write enable; memory writes on rising edge
MemRead  output  1  memory read enable
Read_Data  input  64  combinational read data from memory

Behaviour:
- Reset (sync): state=IDLE; busy=0, resp_valid=0, resp_err=0, load_data=0, Mem_Addr=0, Write_Data=0.
- MemWrite and MemRead are gated by !reset combinationally, so no memory write occurs on any edge where reset=1.
- Reset mid-operation aborts the access; an RMW in progress leaves memory unchanged.
- Acceptance: in IDLE with req_valid=1, latch write, funct3, aligned address addr&~7, offset addr[2:0] and wdata.
- Alignment: H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0.
- Range: aligned address + 7 < MEM_BYTES.
- Illegal funct3: load 111; store 1xx.
- Error path: any check fails -> IDLE->RESP with resp_err=1. No MemRead/MemWrite is asserted; load_data is unchanged.
- States:
  - IDLE: busy=0. Go to LOAD (load), STORE (SD), RMW_RD (SB/SH/SW) or RESP (error).
  - LOAD: MemRead=1, Mem_Addr=aligned. Register extracted/extended Read_Data into load_data. ->RESP.
  - STORE: MemWrite=1, Write_Data=wdata. ->RESP.
  - RMW_RD: MemRead=1. Register merged = Read_Data with bytes [off .. off+size-1] replaced by wdata low bytes. ->RMW_WR.
  - RMW_WR: MemWrite=1, Write_Data=merged. ->RESP.
  - RESP: resp_valid=1, busy=1, resp_err as determined. ->IDLE.
- MemRead/MemWrite are 0 in every other state. Mem_Addr holds the latched aligned address outside IDLE.
- Latency from acceptance edge to resp_valid: load/SD 2 cycles, SB/SH/SW 3 cycles, error 1 cycle.
- Next request is accepted no earlier than the cycle after RESP. Back-to-back throughput: one access per 3 (load/SD) or 4 (RMW) cycles.
- Extraction: byte = bits[8*off +: 8], half = [8*off +: 16], word = [8*off +: 32].
  - LB/LH/LW sign-extend to 64 bits.
  - LBU/LHU/LWU zero-extend.
  - LD passes all 64 bits.
- Byte order is little-endian: byte at address A is Read_Data[8*(A&7) +: 8].
- req_valid while busy=1 is ignored; the pipeline must hold it.

Test Plan:
- Reset, then SD 0x1122334455667788 @8 -> MemWrite=1 with Mem_Addr=8 exactly one cycle; resp_valid 2 cycles after accept, resp_err=0.
- After that store, LB @15 -> load_data=0x0000000000000011. LB @8 -> 0xFFFFFFFFFFFFFF88. LBU @8 -> 0x0000000000000088.
- SH 0xABCD @10 -> RMW_RD then RMW_WR with Write_Data=0x11223344ABCD7788; a following LD @8 returns 0x11223344ABCD7788.
- LW @6, LH @9 and LD @64 (MEM_BYTES=64) -> each gives resp_err=1 one cycle after accept. MemRead/MemWrite are never asserted and memory is unchanged.
- SB 0xFF @3, with reset asserted during RMW_RD -> no MemWrite; after reset, LD @0 returns 0, busy=0, resp_valid=0.
- Load funct3=111 -> resp_err=1. req_valid pulsed while busy -> ignored, with no extra resp_valid.
